rx_iq_stream_arbiter: RTL and testbench

// Buffers RX IQ pairs from the spectrum and voice DDC outputs in two small FIFOs.

---
 rtl/rx_iq_stream_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rx_iq_stream_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_stream_arbiter.sv
// RX IQ stream arbiter: per-channel voice/spectrum FIFOs with a voice-priority scheduler that
// hands one IQ pair per bus read request. Optional drop counters: define RX_IQ_ARB_DROPCNT_EN.
module rx_iq_stream_arbiter #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  voice_valid,
  input  logic [15:0]           VOICE_I,
  input  logic [15:0]           VOICE_Q,
  input  logic                  spec_valid,
  input  logic [15:0]           SPEC_I,
  input  logic [15:0]           SPEC_Q,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [15:0]           out_I,
  output logic [15:0]           out_Q,
  output logic                  out_src,
  output logic                  out_empty,
  output logic [DEPTH_LOG2:0]   voice_level,
  output logic [DEPTH_LOG2:0]   spec_level,
  output logic                  voice_ovf,
  output logic                  spec_ovf,
  input  logic                  ovf_clear,
  output logic [7:0]            voice_drops,
  output logic [7:0]            spec_drops
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW   = DEPTH_LOG2;
  localparam int unsigned LevelW = DEPTH_LOG2 + 1;
  localparam int unsigned StW    = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

  state_e state_q, state_d;

  logic [31:0] voice_mem [Depth];
  logic [31:0] spec_mem  [Depth];

  logic [PtrW-1:0]   voice_wr_ptr_q, voice_rd_ptr_q, spec_wr_ptr_q, spec_rd_ptr_q;
  logic [LevelW-1:0] voice_level_q, voice_level_d, spec_level_q, spec_level_d;
  logic [StW-1:0]    starve_q, starve_d;
  logic [15:0]       out_i_q, out_q_q;
  logic              out_src_q, out_empty_q;
  logic              voice_ovf_q, spec_ovf_q;

  logic voice_full, spec_full, voice_ne, spec_ne;
  logic voice_wr, spec_wr, voice_pop, spec_pop;
  logic voice_drop, spec_drop;

  // Full is judged on the pre-edge level, so a same-cycle pop never rescues a write.
  assign voice_full = (voice_level_q == LevelW'(Depth));
  assign spec_full  = (spec_level_q == LevelW'(Depth));
  assign voice_ne   = (voice_level_q != '0);
  assign spec_ne    = (spec_level_q != '0);
  assign voice_wr   = voice_valid & ~voice_full;
  assign spec_wr    = spec_valid & ~spec_full;
  assign voice_drop = voice_valid & voice_full;
  assign spec_drop  = spec_valid & spec_full;

  always_comb begin
    state_d   = state_q;
    voice_pop = 1'b0;
    spec_pop  = 1'b0;
    starve_d  = starve_q;
    unique case (state_q)
      StIdle: begin
        if (rd_req) state_d = StGrant;
      end
      StGrant: begin
        state_d = StAck;
        if (voice_ne && (!spec_ne || (starve_q < StW'(STARVE_LIMIT)))) begin
          voice_pop = 1'b1;
          if (spec_ne && (starve_q != StW'(STARVE_LIMIT))) starve_d = starve_q + StW'(1);
        end else if (spec_ne) begin
          spec_pop = 1'b1;
          starve_d = '0;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign voice_level_d = voice_level_q + LevelW'(voice_wr) - LevelW'(voice_pop);
  assign spec_level_d  = spec_level_q + LevelW'(spec_wr) - LevelW'(spec_pop);

  always_ff @(posedge clk_in) begin
    if (voice_wr) voice_mem[voice_wr_ptr_q] <= {VOICE_I, VOICE_Q};
    if (spec_wr)  spec_mem[spec_wr_ptr_q]   <= {SPEC_I, SPEC_Q};
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q        <= StIdle;
      voice_wr_ptr_q <= '0;
      voice_rd_ptr_q <= '0;
      spec_wr_ptr_q  <= '0;
      spec_rd_ptr_q  <= '0;
      voice_level_q  <= '0;
      spec_level_q   <= '0;
      starve_q       <= '0;
      out_i_q        <= '0;
      out_q_q        <= '0;
      out_src_q      <= 1'b0;
      out_empty_q    <= 1'b0;
      voice_ovf_q    <= 1'b0;
      spec_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      voice_level_q <= voice_level_d;
      spec_level_q  <= spec_level_d;
      starve_q      <= starve_d;
      if (voice_wr)  voice_wr_ptr_q <= voice_wr_ptr_q + PtrW'(1);
      if (spec_wr)   spec_wr_ptr_q  <= spec_wr_ptr_q + PtrW'(1);
      if (voice_pop) voice_rd_ptr_q <= voice_rd_ptr_q + PtrW'(1);
      if (spec_pop)  spec_rd_ptr_q  <= spec_rd_ptr_q + PtrW'(1);
      if (state_q == StGrant) begin
        if (voice_pop) begin
          {out_i_q, out_q_q} <= voice_mem[voice_rd_ptr_q];
          out_src_q          <= 1'b1;
          out_empty_q        <= 1'b0;
        end else if (spec_pop) begin
          {out_i_q, out_q_q} <= spec_mem[spec_rd_ptr_q];
          out_src_q          <= 1'b0;
          out_empty_q        <= 1'b0;
        end else begin
          // Empty response keeps the last source indication.
          out_i_q     <= '0;
          out_q_q     <= '0;
          out_empty_q <= 1'b1;
        end
      end
      if (ovf_clear) begin
        voice_ovf_q <= 1'b0;
        spec_ovf_q  <= 1'b0;
      end else begin
        if (voice_drop) voice_ovf_q <= 1'b1;
        if (spec_drop)  spec_ovf_q  <= 1'b1;
      end
    end
  end

`ifdef RX_IQ_ARB_DROPCNT_EN
  logic [7:0] voice_drops_q, spec_drops_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      voice_drops_q <= '0;
      spec_drops_q  <= '0;
    end else if (ovf_clear) begin
      voice_drops_q <= '0;
      spec_drops_q  <= '0;
    end else begin
      if (voice_drop && (voice_drops_q != 8'hff)) voice_drops_q <= voice_drops_q + 8'd1;
      if (spec_drop && (spec_drops_q != 8'hff))   spec_drops_q  <= spec_drops_q + 8'd1;
    end
  end

  assign voice_drops = voice_drops_q;
  assign spec_drops  = spec_drops_q;
`else
  assign voice_drops = '0;
  assign spec_drops  = '0;
`endif

  assign rd_ack      = (state_q == StAck);
  assign out_I       = out_i_q;
  assign out_Q       = out_q_q;
  assign out_src     = out_src_q;
  assign out_empty   = out_empty_q;
  assign voice_level = voice_level_q;
  assign spec_level  = spec_level_q;
  assign voice_ovf   = voice_ovf_q;
  assign spec_ovf    = spec_ovf_q;

endmodule

// File: tb/tb_rx_iq_stream_arbiter.sv
// Self-checking bench for rx_iq_stream_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_rx_iq_stream_arbiter;

  localparam int Starve = 3;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        voice_valid = 1'b0, spec_valid = 1'b0, rd_req = 1'b0, ovf_clear = 1'b0;
  logic [15:0] VOICE_I = '0, VOICE_Q = '0, SPEC_I = '0, SPEC_Q = '0;
  logic        rd_ack, out_src, out_empty, voice_ovf, spec_ovf;
  logic [15:0] out_I, out_Q;
  logic [4:0]  voice_level, spec_level;
  logic [7:0]  voice_drops, spec_drops;

  rx_iq_stream_arbiter #(.DEPTH_LOG2(4), .STARVE_LIMIT(Starve)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .voice_valid (voice_valid),
    .VOICE_I     (VOICE_I),
    .VOICE_Q     (VOICE_Q),
    .spec_valid  (spec_valid),
    .SPEC_I      (SPEC_I),
    .SPEC_Q      (SPEC_Q),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .out_I       (out_I),
    .out_Q       (out_Q),
    .out_src     (out_src),
    .out_empty   (out_empty),
    .voice_level (voice_level),
    .spec_level  (spec_level),
    .voice_ovf   (voice_ovf),
    .spec_ovf    (spec_ovf),
    .ovf_clear   (ovf_clear),
    .voice_drops (voice_drops),
    .spec_drops  (spec_drops)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] mv[$];
  logic [31:0] ms[$];
  int          m_phase;  // 0 idle, 1 deciding, 2 acknowledging
  int          m_starve;
  logic [15:0] m_i, m_q;
  logic        m_src, m_empty, m_vovf, m_sovf;
  int          m_vdrop, m_sdrop;
  bit          ack_src[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv.delete();
    ms.delete();
    m_phase = 0; m_starve = 0;
    m_i = '0; m_q = '0; m_src = 1'b0; m_empty = 1'b0;
    m_vovf = 1'b0; m_sovf = 1'b0; m_vdrop = 0; m_sdrop = 0;
  endtask

  task automatic check_all();
    chk("rd_ack", 32'(rd_ack), 32'(m_phase == 2));
    chk("out_I", 32'(out_I), 32'(m_i));
    chk("out_Q", 32'(out_Q), 32'(m_q));
    chk("out_src", 32'(out_src), 32'(m_src));
    chk("out_empty", 32'(out_empty), 32'(m_empty));
    chk("voice_level", 32'(voice_level), 32'(mv.size()));
    chk("spec_level", 32'(spec_level), 32'(ms.size()));
    chk("voice_ovf", 32'(voice_ovf), 32'(m_vovf));
    chk("spec_ovf", 32'(spec_ovf), 32'(m_sovf));
`ifdef RX_IQ_ARB_DROPCNT_EN
    chk("voice_drops", 32'(voice_drops), 32'(m_vdrop));
    chk("spec_drops", 32'(spec_drops), 32'(m_sdrop));
`else
    chk("voice_drops", 32'(voice_drops), 32'd0);
    chk("spec_drops", 32'(spec_drops), 32'd0);
`endif
  endtask

  task automatic tick();
    bit v_ne, s_ne, v_full, s_full;
    logic [31:0] w;
    @(posedge clk_in);
    v_ne   = mv.size() > 0;
    s_ne   = ms.size() > 0;
    v_full = mv.size() == 16;
    s_full = ms.size() == 16;
    if (m_phase == 1) begin
      if (v_ne && (!s_ne || m_starve < Starve)) begin
        w = mv.pop_front();
        m_i = w[31:16]; m_q = w[15:0]; m_src = 1'b1; m_empty = 1'b0;
        if (s_ne && m_starve < Starve) m_starve++;
      end else if (s_ne) begin
        w = ms.pop_front();
        m_i = w[31:16]; m_q = w[15:0]; m_src = 1'b0; m_empty = 1'b0;
        m_starve = 0;
      end else begin
        m_i = '0; m_q = '0; m_empty = 1'b1;
      end
    end
    case (m_phase)
      0:       if (rd_req) m_phase = 1;
      1:       m_phase = 2;
      default: m_phase = 0;
    endcase
    if (voice_valid) begin
      if (v_full) begin m_vovf = 1'b1; if (m_vdrop < 255) m_vdrop++; end
      else mv.push_back({VOICE_I, VOICE_Q});
    end
    if (spec_valid) begin
      if (s_full) begin m_sovf = 1'b1; if (m_sdrop < 255) m_sdrop++; end
      else ms.push_back({SPEC_I, SPEC_Q});
    end
    if (ovf_clear) begin
      m_vovf = 1'b0; m_sovf = 1'b0; m_vdrop = 0; m_sdrop = 0;
    end
    #1;
    check_all();
    if (rd_ack === 1'b1) ack_src.push_back(out_src);
    voice_valid = 1'b0; spec_valid = 1'b0; rd_req = 1'b0; ovf_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    check_all();
  endtask

  task automatic read_pair();
    rd_req = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic put_voice(input logic [15:0] i, input logic [15:0] q);
    voice_valid = 1'b1; VOICE_I = i; VOICE_Q = q;
  endtask

  task automatic put_spec(input logic [15:0] i, input logic [15:0] q);
    spec_valid = 1'b1; SPEC_I = i; SPEC_Q = q;
  endtask

  logic [11:0] order;
  int pv, ps, pr;

  initial begin
    model_reset();
    do_reset();

    // Empty read: ack two cycles after the request, zero data flagged empty.
    rd_req = 1'b1;
    tick();
    chk("empty_no_early_ack", 32'(rd_ack), 32'd0);
    tick();
    chk("empty_ack", 32'(rd_ack), 32'd1);
    chk("empty_flag", 32'(out_empty), 32'd1);
    chk("empty_data", {out_I, out_Q}, 32'd0);
    tick();

    // Voice first, then spectrum.
    put_voice(16'd100, 16'hff9c);
    put_spec(16'd7, 16'd8);
    tick();
    read_pair();
    chk("voice_pair", {out_I, out_Q}, {16'd100, 16'hff9c});
    chk("voice_src", 32'(out_src), 32'd1);
    read_pair();
    chk("spec_pair", {out_I, out_Q}, {16'd7, 16'd8});
    chk("spec_src", 32'(out_src), 32'd0);

    // Starvation limit grant order.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      put_voice(16'(k), 16'(k + 100));
      put_spec(16'(k + 200), 16'(k + 300));
      tick();
    end
    ack_src.delete();
    for (int k = 0; k < 12; k++) read_pair();
    chk("grant_count", 32'(ack_src.size()), 32'd12);
    order = '0;
    for (int k = 0; k < 12 && k < ack_src.size(); k++) order[11-k] = ack_src[k];
    chk("grant_order", 32'(order), 32'(12'b111011101100));

    // Overflow, sticky flag, drop counter and clear.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      put_voice(16'($urandom), 16'($urandom));
      tick();
    end
    chk("ovf_level", 32'(voice_level), 32'd16);
    chk("ovf_flag", 32'(voice_ovf), 32'd1);
`ifdef RX_IQ_ARB_DROPCNT_EN
    chk("ovf_drops", 32'(voice_drops), 32'd1);
`else
    chk("ovf_drops", 32'(voice_drops), 32'd0);
`endif
    ovf_clear = 1'b1;
    tick();
    chk("ovf_cleared", 32'(voice_ovf), 32'd0);

    // Write while full coincides with a pop: write is still dropped.
    rd_req = 1'b1;
    tick();
    put_voice(16'h1234, 16'h5678);
    tick();
    chk("full_pop_level", 32'(voice_level), 32'd15);
    chk("full_pop_ovf", 32'(voice_ovf), 32'd1);
    tick();

    // Reset in the cycle after a request aborts the transfer.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      put_voice(16'(k), 16'(k));
      tick();
    end
    rd_req = 1'b1;
    tick();
    do_reset();
    chk("abort_level", 32'(voice_level), 32'd0);
    tick();
    chk("abort_no_ack", 32'(rd_ack), 32'd0);
    tick();
    read_pair();
    chk("abort_then_empty", 32'(out_empty), 32'd1);

    // Randomized traffic in segments with varying load.
    for (int seg = 0; seg < 8; seg++) begin
      pv = $urandom_range(10, 90);
      ps = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 99) < pv) put_voice(16'($urandom), 16'($urandom));
        if ($urandom_range(0, 99) < ps) put_spec(16'($urandom), 16'($urandom));
        rd_req    = ($urandom_range(0, 99) < pr);
        ovf_clear = ($urandom_range(0, 99) < 3);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
